// File: rtl/nn_layer_seq_pkg.sv
// rtl/nn_layer_seq_pkg.sv - shared widths, activation constants and sequencer state encoding
package nn_pkg;
  localparam int DW             = 24;
  localparam int ACT_SAT_THRESH = 8192;
  localparam int ACT_SHIFT      = 5;
  localparam int ACT_OUT_W      = 8;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    DRAIN,
    WRITE,
    DONE
  } state_t;
endpackage

// File: rtl/nn_layer_seq_if.sv
// rtl/nn_layer_seq_if.sv - scheduler handshake, weight/input memory and output buffer bundle
interface nn_layer_seq_if #(
  parameter int WA_W = 11,
  parameter int XA_W = 7,
  parameter int OA_W = 4
) ();
  logic                         start;
  logic                         busy;
  logic                         done;
  logic [WA_W-1:0]              w_addr;
  logic [nn_pkg::DW-1:0]        w_data;
  logic [XA_W-1:0]              x_addr;
  logic [nn_pkg::DW-1:0]        x_data;
  logic                         out_we;
  logic [OA_W-1:0]              out_addr;
  logic [nn_pkg::ACT_OUT_W-1:0] out_data;
  logic [OA_W:0]                sat_count;

  modport master (
    input  start, w_data, x_data,
    output busy, done, w_addr, x_addr, out_we, out_addr, out_data, sat_count
  );

  modport slave (
    output start, w_data, x_data,
    input  busy, done, w_addr, x_addr, out_we, out_addr, out_data, sat_count
  );
endinterface

// File: rtl/nn_act_clamp.sv
// rtl/nn_act_clamp.sv - clamp/ReLU activation shared by sequential and parallel neuron variants
module nn_act_clamp
  import nn_pkg::*;
(
  input  logic [DW-1:0]        i_s,
  output logic [ACT_OUT_W-1:0] o_act
);
  // Exactly the threshold still takes the window, so bit 13 falls off and 8192 maps to 0
  always_comb begin
    o_act = i_s[ACT_SHIFT +: ACT_OUT_W];
    if (i_s[DW-1]) begin
      o_act = '0;
    end else if (i_s > DW'(ACT_SAT_THRESH)) begin
      o_act = '1;
    end
  end
endmodule

// File: rtl/nn_layer_seq.sv
// rtl/nn_layer_seq.sv - one shared MAC walking every neuron of a fully connected layer
// SAT_CNT_EN builds the saturated-output counter; otherwise sat_count is tied to 0.
module nn_layer_seq
  import nn_pkg::*;
#(
  parameter int N_IN  = 75,
  parameter int N_OUT = 16,
  parameter int WA_W  = 11,
  parameter int XA_W  = 7,
  parameter int OA_W  = 4
) (
  input  logic            clk,
  input  logic            reset,
  nn_layer_seq_if.master  bus
);
  state_t                r_state;
  state_t                w_next;
  logic [OA_W-1:0]       r_j;
  logic [XA_W-1:0]       r_i;
  logic [WA_W-1:0]       r_w_addr;
  logic [DW-1:0]         r_acc;
  logic                  r_pend;
  logic                  r_pend_bias;
  logic [ACT_OUT_W-1:0]  r_out_data;

  logic                  w_busy;
  logic                  w_done;
  logic                  w_we;
  logic                  w_last_in;
  logic                  w_last_out;
  logic [DW-1:0]         w_prod;
  logic [DW-1:0]         w_acc_sum;
  logic [ACT_OUT_W-1:0]  w_act;

  assign w_last_in  = (r_i == XA_W'(N_IN));
  assign w_last_out = (r_j == OA_W'(N_OUT - 1));

  // Memory data lags the address by one cycle; r_pend marks a word arriving now
  assign w_prod    = bus.x_data * bus.w_data;
  assign w_acc_sum = r_acc + (r_pend_bias ? bus.w_data : w_prod);

  nn_act_clamp u_act (
    .i_s   (w_acc_sum),
    .o_act (w_act)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    w_we   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) w_next = MAC;
      end
      MAC: begin
        w_busy = 1'b1;
        if (w_last_in) w_next = DRAIN;
      end
      DRAIN: begin
        w_busy = 1'b1;
        w_next = WRITE;
      end
      WRITE: begin
        w_busy = 1'b1;
        w_we   = 1'b1;
        w_next = w_last_out ? DONE : MAC;
      end
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_j         <= '0;
      r_i         <= '0;
      r_w_addr    <= '0;
      r_acc       <= '0;
      r_pend      <= 1'b0;
      r_pend_bias <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_pend      <= (r_state == MAC);
      r_pend_bias <= (r_state == MAC) && w_last_in;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_j      <= '0;
            r_i      <= '0;
            r_w_addr <= '0;
            r_acc    <= '0;
          end
        end
        MAC: begin
          if (!w_last_in) begin
            r_i      <= r_i + XA_W'(1);
            r_w_addr <= r_w_addr + WA_W'(1);
          end
          if (r_pend) r_acc <= w_acc_sum;
        end
        DRAIN: begin
          r_acc      <= w_acc_sum;
          r_out_data <= w_act;
        end
        WRITE: begin
          // Bias sits right before the next neuron's first weight, so one step reaches it
          r_acc    <= '0;
          r_i      <= '0;
          r_w_addr <= r_w_addr + WA_W'(1);
          if (!w_last_out) r_j <= r_j + OA_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.out_we   = w_we;
  assign bus.w_addr   = r_w_addr;
  assign bus.x_addr   = r_i;
  assign bus.out_addr = r_j;
  assign bus.out_data = r_out_data;

`ifdef SAT_CNT_EN
  logic [OA_W:0] r_sat_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sat_count <= '0;
    end else if ((r_state == IDLE) && bus.start) begin
      r_sat_count <= '0;
    end else if ((r_state == WRITE) && (r_out_data == '1)) begin
      r_sat_count <= r_sat_count + (OA_W + 1)'(1);
    end
  end

  assign bus.sat_count = r_sat_count;
`else
  assign bus.sat_count = '0;
`endif
endmodule

// File: tb/tb_nn_layer_seq.sv
// tb/tb_nn_layer_seq.sv - randomized scoreboard bench for the time-multiplexed layer sequencer
module tb_nn_layer_seq;
  localparam int N_IN   = 75;
  localparam int N_OUT  = 16;
  localparam int WA_W   = 11;
  localparam int XA_W   = 7;
  localparam int OA_W   = 4;
  localparam int DW     = 24;
  localparam int STRIDE = N_IN + 1;
  localparam int RUN_LAT = N_OUT * (N_IN + 3);

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  nn_layer_seq_if #(.WA_W(WA_W), .XA_W(XA_W), .OA_W(OA_W)) bus ();

  nn_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .WA_W(WA_W), .XA_W(XA_W), .OA_W(OA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] rom  [0:(1<<WA_W)-1];
  logic [DW-1:0] xmem [0:(1<<XA_W)-1];

  always @(posedge clk) begin
    bus.w_data <= rom[bus.w_addr];
    bus.x_data <= xmem[bus.x_addr];
  end

  typedef struct {
    int addr;
    int data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   n_we  = 0;
  int   n_done = 0;
  bit   addr_chk = 1'b0;
  bit   seen [0:STRIDE-1];
  exp_t mon_e;
  int   mon_idx;
  int   nsat;
  int   cyc;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int act_ref(input logic [DW-1:0] s);
    if (s[DW-1]) return 0;
    if (s > 24'd8192) return 255;
    return int'(s >> 5) & 255;
  endfunction

  function automatic int sat_exp(input int n);
`ifdef SAT_CNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  // Reference: dot product of inputs and weights plus bias, 24-bit wrap, then activation
  task automatic push_expected(output int n_sat);
    logic [DW-1:0] acc;
    logic [47:0]   p;
    int            v;
    n_sat = 0;
    for (int j = 0; j < N_OUT; j++) begin
      acc = '0;
      for (int i = 0; i < N_IN; i++) begin
        p   = 48'(xmem[i]) * 48'(rom[j*STRIDE + i]);
        acc = acc + p[DW-1:0];
      end
      acc = acc + rom[j*STRIDE + N_IN];
      v = act_ref(acc);
      if (v == 255) n_sat++;
      exp_q.push_back('{addr: j, data: v});
    end
  endtask

  task automatic clear_mem();
    for (int a = 0; a < (1<<WA_W); a++) rom[a] = '0;
    for (int a = 0; a < (1<<XA_W); a++) xmem[a] = '0;
  endtask

  task automatic fill_random(input int mode);
    int v;
    clear_mem();
    for (int i = 0; i < N_IN; i++)
      xmem[i] = (mode == 0) ? DW'($urandom) : DW'($urandom_range(0, 63));
    for (int j = 0; j < N_OUT; j++) begin
      for (int i = 0; i < N_IN; i++) begin
        v = int'($urandom_range(0, 20)) - 8;
        rom[j*STRIDE + i] = (mode == 0) ? DW'($urandom) : DW'(v);
      end
      v = int'($urandom_range(0, 4000)) - 2000;
      rom[j*STRIDE + N_IN] = (mode == 0) ? DW'($urandom) : DW'(v);
    end
  endtask

  task automatic run_layer(input int extra_start, output int n_cyc);
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    check("busy_after_start", int'(bus.busy), 1);
    check("sat_cleared_at_start", int'(bus.sat_count), 0);
    n_cyc = 0;
    while (!bus.done && n_cyc < 3000) begin
      if (n_cyc == extra_start) bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n_cyc++;
    end
    if (n_cyc >= 3000) check("done_timeout", 0, 1);
    check("busy_low_at_done", int'(bus.busy), 0);
  endtask

  task automatic settle_and_count(input int exp_we, input int exp_done);
    repeat (3) @(posedge clk);
    #1;
    check("write_count", n_we, exp_we);
    check("done_count", n_done, exp_done);
    check("scoreboard_empty", exp_q.size(), 0);
    n_we   = 0;
    n_done = 0;
  endtask

  always @(negedge clk) begin
    if (reset && bus.out_we) begin
      n_we++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_addr", int'(bus.out_addr), mon_e.addr);
        check("out_data", int'(bus.out_data), mon_e.data);
      end
    end
    if (bus.done) n_done++;
    if (addr_chk && bus.busy && int'(bus.w_addr) >= 2*STRIDE && int'(bus.w_addr) < 3*STRIDE) begin
      mon_idx = int'(bus.w_addr) - 2*STRIDE;
      seen[mon_idx] = 1'b1;
      if (mon_idx < N_IN) check("x_addr_align", int'(bus.x_addr), mon_idx);
    end
  end

  initial begin
    int n_seen;
    bus.start = 1'b0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_out_we", int'(bus.out_we), 0);
    check("rst_w_addr", int'(bus.w_addr), 0);
    check("rst_x_addr", int'(bus.x_addr), 0);
    check("rst_out_addr", int'(bus.out_addr), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_sat_count", int'(bus.sat_count), 0);
    reset = 1'b1;

    // All ones, zero bias: every neuron sums to 75
    for (int a = 0; a < N_IN; a++) xmem[a] = 24'd1;
    for (int j = 0; j < N_OUT; j++)
      for (int i = 0; i < N_IN; i++) rom[j*STRIDE + i] = 24'd1;
    push_expected(nsat);
    run_layer(-1, cyc);
    check("latency_ones", cyc, RUN_LAT);
    check("sat_ones", int'(bus.sat_count), sat_exp(nsat));
    settle_and_count(N_OUT, 1);

    // Negative bias, and the 8192/8193 saturation boundary on neuron 1
    clear_mem();
    rom[N_IN] = 24'hFFFFFF;
    rom[STRIDE] = 24'd1;
    xmem[0] = 24'd8192;
    push_expected(nsat);
    run_layer(-1, cyc);
    check("sat_8192", int'(bus.sat_count), sat_exp(nsat));
    settle_and_count(N_OUT, 1);
    xmem[0] = 24'd8193;
    push_expected(nsat);
    run_layer(-1, cyc);
    check("sat_8193", int'(bus.sat_count), sat_exp(nsat));
    check("sat_8193_model", nsat, 1);
    settle_and_count(N_OUT, 1);

    // Stray start mid-run must not disturb the sequence
    fill_random(1);
    push_expected(nsat);
    run_layer(100, cyc);
    check("latency_restart_ignored", cyc, RUN_LAT);
    check("sat_small", int'(bus.sat_count), sat_exp(nsat));
    settle_and_count(N_OUT, 1);

    // Abort by reset partway through
    fill_random(0);
    push_expected(nsat);
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (500) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_out_we", int'(bus.out_we), 0);
    check("abort_done", int'(bus.done), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    n_we = 0;
    n_done = 0;
    repeat (1300) @(posedge clk);
    #1;
    check("abort_no_done", n_done, 0);
    check("abort_no_write", n_we, 0);
    push_expected(nsat);
    run_layer(-1, cyc);
    check("latency_after_abort", cyc, RUN_LAT);
    settle_and_count(N_OUT, 1);

    // Back-to-back runs with the address walk of neuron 2 observed
    fill_random(1);
    for (int k = 0; k < STRIDE; k++) seen[k] = 1'b0;
    addr_chk = 1'b1;
    push_expected(nsat);
    push_expected(nsat);
    run_layer(-1, cyc);
    addr_chk = 1'b0;
    check("sat_b2b_first", int'(bus.sat_count), sat_exp(nsat));
    run_layer(-1, cyc);
    check("latency_b2b_second", cyc, RUN_LAT);
    check("sat_b2b_second", int'(bus.sat_count), sat_exp(nsat));
    settle_and_count(2*N_OUT, 2);
    n_seen = 0;
    for (int k = 0; k < STRIDE; k++) n_seen += int'(seen[k]);
    check("neuron2_addr_span", n_seen, STRIDE);

    // start presented during the done cycle is dropped
    fill_random(0);
    push_expected(nsat);
    run_layer(-1, cyc);
    bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    check("start_in_done_ignored", int'(bus.busy), 0);
    settle_and_count(N_OUT, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
